// File: rtl/serial_reduce_imp.sv
// serial_reduce_imp: bit-serial implication fold over a handshaked vector, one bit per clock, LSB first.
// Define SERIAL_REDUCE_PIERCE_EN to swap the implication cell for a Pierce (NOR) cell.
module serial_reduce_imp #(
  parameter int COUNT_OF_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [COUNT_OF_BITS-1:0] bitvector,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     reduce,
  output logic                     busy
);
  localparam int IW = $clog2(COUNT_OF_BITS) + 1;
  localparam logic [IW-1:0] LAST = IW'(COUNT_OF_BITS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [COUNT_OF_BITS-1:0] sh;
  logic [IW-1:0] idx;
  logic acc, step, accept;
  generate
    if (COUNT_OF_BITS < 1) begin : g_bad_width
      $error("serial_reduce_imp: COUNT_OF_BITS must be >= 1");
    end
  endgenerate
`ifdef SERIAL_REDUCE_PIERCE_EN
  assign step = ~(sh[0] | acc);
`else
  assign step = ~sh[0] | acc;
`endif
  assign accept    = (state == IDLE) && in_valid;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign reduce    = acc;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb begin
    state_nx = state;
    if (accept) state_nx = (COUNT_OF_BITS == 1) ? DONE : RUN;
    else if (state == RUN && idx == LAST) state_nx = DONE;
    else if (state == DONE && out_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh  <= '0;
      acc <= 1'b0;
      idx <= '0;
    end else if (accept) begin
      sh  <= bitvector >> 1;
      acc <= bitvector[0];
      idx <= IW'(1);
    end else if (state == RUN) begin
      sh  <= sh >> 1;
      acc <= step;
      idx <= idx + 1'b1;
    end
endmodule

// File: tb/tb_serial_reduce_imp.sv
// tb_serial_reduce_imp: scoreboard bench for the N=4 and N=1 serial implication reducers.
module tb_serial_reduce_imp;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic iv4 = 1'b0, or4 = 1'b0, ir4, ov4, rd4, bz4;
  logic [3:0] bv4 = '0;
  logic iv1 = 1'b0, or1 = 1'b0, ir1, ov1, rd1, bz1;
  logic [0:0] bv1 = '0;
  int errs = 0, checks = 0;
  bit q[$];

  serial_reduce_imp #(.COUNT_OF_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .bitvector(bv4),
    .out_valid(ov4), .out_ready(or4), .reduce(rd4), .busy(bz4));
  serial_reduce_imp #(.COUNT_OF_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .bitvector(bv1),
    .out_valid(ov1), .out_ready(or1), .reduce(rd1), .busy(bz1));

  function automatic bit model(logic [31:0] v, int n);
    bit a = v[0];
    for (int i = 1; i < n; i++)
`ifdef SERIAL_REDUCE_PIERCE_EN
      a = ~(v[i] | a);
`else
      a = ~v[i] | a;
`endif
    return a;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send4(input logic [3:0] v, input int hold, input bit poke);
    int cnt = 0;
    bit exp;
    @(negedge clk);
    check("in_ready_idle", 32'(ir4), 1);
    iv4 = 1'b1;
    bv4 = v;
    q.push_back(model(32'(v), 4));
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0;
    bv4 = ~v;
    while (!ov4 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", cnt, 3);
    check("busy_done", 32'(bz4), 1);
    for (int k = 0; k < hold; k++) begin
      if (poke) begin
        iv4 = 1'b1;
        bv4 = ~v;
      end
      @(negedge clk);
      check("hold_valid", 32'(ov4), 1);
      check("hold_in_ready", 32'(ir4), 0);
      check("hold_reduce", 32'(rd4), 32'(q[0]));
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    exp = q.pop_front();
    check("reduce", 32'(rd4), 32'(exp));
    @(negedge clk);
    or4 = 1'b0;
    check("in_ready_after", 32'(ir4), 1);
    check("out_valid_after", 32'(ov4), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(ir4), 1);
    check("rst_out_valid", 32'(ov4), 0);
    check("rst_reduce", 32'(rd4), 0);
    check("rst_busy", 32'(bz4), 0);
    send4(4'b0000, 0, 1'b0);
    send4(4'b1110, 0, 1'b0);
    send4(4'b1000, 5, 1'b1);
    send4(4'b0010, 1, 1'b0);
    for (int r = 0; r < 6; r++) send4(4'($urandom_range(0, 15)), r % 3, 1'b0);
    @(negedge clk);
    iv4 = 1'b1;
    bv4 = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(ov4), 0);
    check("abort_busy", 32'(bz4), 0);
    check("abort_in_ready", 32'(ir4), 1);
    @(negedge clk);
    rst = 1'b0;
    send4(4'b0000, 0, 1'b0);
    @(negedge clk);
    check("n1_in_ready", 32'(ir1), 1);
    iv1 = 1'b1;
    bv1 = 1'b1;
    q.push_back(model(32'(bv1), 1));
    @(posedge clk);
    @(negedge clk);
    iv1 = 1'b0;
    check("n1_out_valid", 32'(ov1), 1);
    check("n1_busy", 32'(bz1), 1);
    check("n1_reduce", 32'(rd1), 32'(q.pop_front()));
    or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
    check("n1_out_valid_after", 32'(ov1), 0);
    check("n1_in_ready_after", 32'(ir1), 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/serial_reduce_imp.md
Name: serial_reduce_imp

Overview:
- Bit-serial, handshaked counterpart of the combinational implication reducer.
- Accepts a COUNT_OF_BITS-wide vector over a valid/ready input port.
- Consumes one bit per clock, LSB first, through a single implication cell (Pierce/NOR cell when the optional feature is enabled).
- Returns the 1-bit fold on a valid/ready output port. Used where area matters more than latency, and as a cycle-accurate cross-check of the combinational reducer.

Parameters:
- COUNT_OF_BITS, 4, vector width; legal range >= 1; elaboration error if < 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  bitvector valid
- in_ready  output  1  block can accept a vector
- bitvector  input  COUNT_OF_BITS  operand, sampled on in handshake
- out_valid  output  1  reduce holds a finished result
- out_ready  input  1  consumer accepts result
- reduce  output  1  fold result
- busy  output  1  high in RUN or DONE

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst); deassertion is synchronous to clk in the surrounding design.
- Fold definition, N = COUNT_OF_BITS:
  - acc0 = bitvector[0]
  - acc_i = (~bitvector[i]) | acc_{i-1}, for i = 1..N-1
  - reduce = acc_{N-1}
- Internal registers: state, shift register sh[N-1:0], accumulator acc, index idx of width clog2(N)+1.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready at an edge:
    - sh <= bitvector >> 1, acc <= bitvector[0], idx <= 1.
    - Next state is DONE if N == 1, else RUN.
  - RUN: each edge, acc <= ~sh[0] | acc, sh <= sh >> 1, idx <= idx + 1. When idx == N-1 at the edge, next state is DONE.
  - DONE: out_valid = 1; reduce = acc, stable. On out_valid & out_ready → IDLE.
- in_ready = (state == IDLE). in_valid is ignored outside IDLE; bitvector is not re-sampled there.
- out_valid = (state == DONE); busy = (state != IDLE). reduce is driven from acc in every state and is meaningful only while out_valid = 1.
- Latency: out_valid rises N-1 edges after the accepting edge (0 for N = 1). Throughput: one vector per N+1 cycles minimum (acceptance, N-1 RUN cycles, at least one DONE cycle).
- No overlap: a new vector is accepted only in IDLE, i.e. at earliest the cycle after the output handshake. Combinational in_ready from out_ready is forbidden.
- out_ready held low in DONE: result and out_valid are held indefinitely.
- Reset values: state = IDLE, acc = 0, sh = 0, idx = 0. Outputs after reset: in_ready = 1, out_valid = 0, reduce = 0, busy = 0.
- Reset mid-RUN or in DONE: the operation is aborted immediately with no output produced; the block returns to IDLE.

Optional Feature:
- Macro: SERIAL_REDUCE_PIERCE_EN.
- Defined: the step becomes acc_i = ~(bitvector[i] | acc_{i-1}) (Pierce/NOR); acc0, timing and handshake are unchanged.
- Undefined: implication step as above.

Test Plan:
- Reset release, then N = 4, bitvector = 4'b0000 → in_ready = 1 after reset; out_valid rises 3 edges after acceptance; reduce = 1.
- bitvector = 4'b1110 with out_ready = 1 → reduce = 0; in_ready returns to 1 the cycle after the output handshake.
- bitvector = 4'b1000 with out_ready held low for 5 cycles → out_valid and reduce = 1 stable throughout; a new in_valid during that time is not accepted.
- N = 1 instance, bitvector = 1'b1 → out_valid asserted in the cycle after the accepting edge, reduce = 1.
- rst pulsed after the second RUN edge → out_valid = 0 and busy = 0 immediately; the next vector 4'b0000 yields reduce = 1 normally.
- With SERIAL_REDUCE_PIERCE_EN defined, N = 4: 4'b0000 → reduce = 1; 4'b0010 → reduce = 0.
